gamepad_pmod_tx: RTL



---
 rtl/gamepad_pmod_tx.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/gamepad_pmod_tx.sv
// rtl/gamepad_pmod_tx.sv - Gamepad Pmod 3-wire frame serializer (data/clk/latch)
module gamepad_pmod_tx #(
    parameter int BIT_WIDTH   = 24,
    parameter int HALF_PERIOD = 4,
    parameter int GAP_CYCLES  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BIT_WIDTH-1:0] frame_data,
    input  logic                 frame_valid,
    output logic                 frame_ready,
    output logic                 frame_done,
    output logic                 busy,
    output logic                 pmod_data,
    output logic                 pmod_clk,
    output logic                 pmod_latch
);

    localparam int CNT_MAX = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;

    localparam logic [CNT_W-1:0] HP_LAST  = CNT_W'(HALF_PERIOD - 1);
    // Ready is raised one cycle early so the IDLE cycle completes the gap and
    // a held frame_valid restarts with no bubble.
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BIT_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        HI,
        LO,
        LATCH,
        GAP
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     phase_q, phase_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [BIT_WIDTH-1:0] shift_q, shift_d;
    logic                 ready_d, done_d, busy_d, data_d, clk_d, latch_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            frame_ready <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
            pmod_data   <= 1'b0;
            pmod_clk    <= 1'b0;
            pmod_latch  <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            frame_ready <= ready_d;
            frame_done  <= done_d;
            busy        <= busy_d;
            pmod_data   <= data_d;
            pmod_clk    <= clk_d;
            pmod_latch  <= latch_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        ready_d = frame_ready;
        done_d  = 1'b0;
        busy_d  = busy;
        data_d  = pmod_data;
        clk_d   = pmod_clk;
        latch_d = pmod_latch;

        unique case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                data_d  = 1'b0;
                clk_d   = 1'b0;
                latch_d = 1'b0;
                if (frame_valid && frame_ready) begin
                    shift_d = frame_data;
                    data_d  = frame_data[BIT_WIDTH-1];
                    clk_d   = 1'b1;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    phase_d = '0;
                    idx_d   = '0;
                    state_d = HI;
                end
            end
            HI: begin
                if (phase_q == HP_LAST) begin
                    clk_d   = 1'b0;
                    phase_d = '0;
                    state_d = LO;
                end else begin
                    phase_d = phase_q + CNT_W'(1);
                end
            end
            LO: begin
                if (phase_q == HP_LAST) begin
                    phase_d = '0;
                    if (idx_q == IDX_LAST) begin
                        latch_d = 1'b1;
                        data_d  = 1'b0;
                        state_d = LATCH;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        shift_d = shift_q << 1;
                        data_d  = shift_d[BIT_WIDTH-1];
                        clk_d   = 1'b1;
                        state_d = HI;
                    end
                end else begin
                    phase_d = phase_q + CNT_W'(1);
                end
            end
            LATCH: begin
                if (phase_q == HP_LAST) begin
                    latch_d = 1'b0;
                    done_d  = 1'b1;
                    phase_d = '0;
                    if (GAP_CYCLES == 1) begin
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                    end
                end else begin
                    phase_d = phase_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (phase_q == GAP_LAST) begin
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    phase_d = phase_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
